// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying PC, instruction, payload, exception code and BD flag.
// Latency: one cycle from accept to out_valid when empty; one beat per cycle while out_ready=1.
// Backpressure: SKID=1 gives a registered in_ready from a 2-entry skid; SKID=0 gives a combinational in_ready.
module pipe_stage_reg #(
    parameter int unsigned DW         = 32,
    parameter bit          SKID       = 1'b1,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    input  logic [DW-1:0] in_data,
    input  logic [4:0]    in_excode,
    input  logic          in_bd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [DW-1:0] out_data,
    output logic [4:0]    out_excode,
    output logic          out_bd,
    output logic [1:0]    occupancy
);

    // One pipeline beat; the same layout is used for the head and the skid slot.
    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [DW-1:0] data;
        logic [4:0]    excode;
        logic          bd;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    // Head entry drives every out_* port; the skid slot only exists to absorb
    // the one beat that arrives while the head is stalled.
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;

    entry_t in_ent;
    logic   accept;
    logic   drain;

    assign in_ent = {in_pc, in_instr, in_data, in_excode, in_bd};

    // With the skid buffer the producer only ever sees a flop output, so a
    // stalled consumer cannot form a combinational path back upstream.
    generate
        if (SKID) begin : g_rdy_reg
            assign in_ready = ~skid_vld_q;
        end else begin : g_rdy_comb
            assign in_ready = ~main_vld_q | out_ready;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign drain  = main_vld_q & out_ready;

    // Next-state selection: reset beats exception flush beats kill flush beats
    // normal handshake traffic. Reset is folded in here so it stays synchronous.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (reset) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_d     = ENTRY_ZERO;
            main_d.pc  = RESET_PC;
            skid_d     = ENTRY_ZERO;
        end else if (req) begin
            // Exception redirect: everything in flight is discarded, including
            // any beat offered this cycle, and the head points at the handler.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_d     = ENTRY_ZERO;
            main_d.pc  = HANDLER_PC;
            skid_d     = ENTRY_ZERO;
        end else if (flush) begin
            // Kill: drop everything but keep the PC so later stages can still
            // see where the squashed stream was.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            main_d     = ENTRY_ZERO;
            main_d.pc  = main_q.pc;
            skid_d     = ENTRY_ZERO;
        end else if (SKID) begin
            if (skid_vld_q) begin
                // Full: in_ready is low, so only a drain can happen. The skid
                // beat moves up to the head, keeping FIFO order.
                if (drain) begin
                    main_d     = skid_q;
                    skid_vld_d = 1'b0;
                end
            end else if (main_vld_q) begin
                if (drain && accept) begin
                    main_d = in_ent;
                end else if (drain) begin
                    // Head leaves with nothing behind it; fields keep their
                    // last values, only the valid bit drops.
                    main_vld_d = 1'b0;
                end else if (accept) begin
                    // Head stalled: park the new beat behind it.
                    skid_d     = in_ent;
                    skid_vld_d = 1'b1;
                end
            end else if (accept) begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end
        end else begin
            // Single-entry mode: in_ready already accounts for a same-cycle
            // drain, so an accept always lands in the head.
            if (accept) begin
                main_d     = in_ent;
                main_vld_d = 1'b1;
            end else if (drain) begin
                main_vld_d = 1'b0;
            end
        end
    end

    // State registers; all reset and flush behaviour is decided above.
    always_ff @(posedge clk) begin
        main_q     <= main_d;
        skid_q     <= skid_d;
        main_vld_q <= main_vld_d;
        skid_vld_q <= skid_vld_d;
    end

    // A skid beat without a head beat would mean a reordering bug.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(skid_vld_q && !main_vld_q));
        end
    end

    assign out_valid  = main_vld_q;
    assign out_pc     = main_q.pc;
    assign out_instr  = main_q.instr;
    assign out_data   = main_q.data;
    assign out_excode = main_q.excode;
    assign out_bd     = main_q.bd;
    assign occupancy  = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid variant (DW=32) and single-entry variant (DW=8).
// Reference model is a bounded queue of beats plus the last-shown head fields.
// Only one DUT is active at a time; the other is held in reset.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [4:0]  excode;
        logic        bd;
    } ent_t;

    typedef struct packed {
        logic       in_rdy;
        logic       out_vld;
        logic [1:0] occ;
        ent_t       e;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_data = '0;
    logic [4:0]  in_excode = '0;
    logic        in_bd = 1'b0;
    int          sel = 0;

    logic reset_a, reset_b;
    assign reset_a = (sel == 0) ? rst : 1'b1;
    assign reset_b = (sel == 1) ? rst : 1'b1;

    logic        in_ready_a, out_valid_a, out_bd_a;
    logic [31:0] out_pc_a, out_instr_a, out_data_a;
    logic [4:0]  out_excode_a;
    logic [1:0]  occupancy_a;

    logic        in_ready_b, out_valid_b, out_bd_b;
    logic [31:0] out_pc_b, out_instr_b;
    logic [7:0]  out_data_b;
    logic [4:0]  out_excode_b;
    logic [1:0]  occupancy_b;

    pipe_stage_reg #(.DW(32), .SKID(1'b1), .RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180)) u_a (
        .clk(clk), .reset(reset_a), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_pc(in_pc), .in_instr(in_instr),
        .in_data(in_data), .in_excode(in_excode), .in_bd(in_bd),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a), .out_instr(out_instr_a),
        .out_data(out_data_a), .out_excode(out_excode_a), .out_bd(out_bd_a), .occupancy(occupancy_a)
    );

    pipe_stage_reg #(.DW(8), .SKID(1'b0), .RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180)) u_b (
        .clk(clk), .reset(reset_b), .req(req), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_instr(in_instr),
        .in_data(in_data[7:0]), .in_excode(in_excode), .in_bd(in_bd),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b), .out_instr(out_instr_b),
        .out_data(out_data_b), .out_excode(out_excode_b), .out_bd(out_bd_b), .occupancy(occupancy_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    ent_t        mq[$];
    ent_t        shown;
    int          m_skid = 1;
    logic [31:0] dmask = 32'hFFFF_FFFF;
    logic [31:0] seen_pc[$];

    function automatic logic m_in_ready();
        if (m_skid != 0) return (mq.size() < 2);
        return (mq.size() == 0) || (out_ready == 1'b1);
    endfunction

    function automatic obs_t expect_now();
        obs_t o;
        o.in_rdy  = m_in_ready();
        o.out_vld = (mq.size() != 0);
        o.occ     = 2'(mq.size());
        o.e       = shown;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        if (sel == 0) begin
            o.in_rdy  = in_ready_a;
            o.out_vld = out_valid_a;
            o.occ     = occupancy_a;
            o.e       = {out_pc_a, out_instr_a, out_data_a, out_excode_a, out_bd_a};
        end else begin
            o.in_rdy  = in_ready_b;
            o.out_vld = out_valid_b;
            o.occ     = occupancy_b;
            o.e       = {out_pc_b, out_instr_b, {24'd0, out_data_b}, out_excode_b, out_bd_b};
        end
        return o;
    endfunction

    // Advance one clock: model the edge from the spec's rules, log what the DUT drained.
    task automatic tick();
        obs_t o;
        bit   acc, drn, r, q, f;
        ent_t ie;
        o = observe();
        if (o.out_vld === 1'b1 && out_ready === 1'b1) seen_pc.push_back(o.e.pc);
        acc = in_valid && m_in_ready();
        drn = (mq.size() != 0) && out_ready;
        r = rst; q = req; f = flush;
        ie = {in_pc, in_instr, in_data & dmask, in_excode, in_bd};
        @(posedge clk);
        if (r || q) begin
            mq.delete();
            shown = '0;
            shown.pc = r ? 32'h0000_3000 : 32'h0000_4180;
        end else if (f) begin
            logic [31:0] keep_pc;
            keep_pc = shown.pc;
            mq.delete();
            shown = '0;
            shown.pc = keep_pc;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(ie);
            if (mq.size() != 0) shown = mq[0];
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req = 0; flush = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic rand_fields();
        in_instr  = $urandom;
        in_data   = $urandom;
        in_excode = 5'($urandom);
        in_bd     = 1'($urandom);
    endtask

    task automatic test_reset();
        sel = 0; m_skid = 1; dmask = 32'hFFFF_FFFF;
        idle(); rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_vec++;
        if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL reset_model: got %h want %h", observe(), expect_now());
        end
        n_vec++;
        if (out_pc_a !== 32'h3000 || out_valid_a !== 1'b0 || occupancy_a !== 2'd0 || in_ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_values: got pc=%h vld=%b occ=%0d rdy=%b want pc=00003000 vld=0 occ=0 rdy=1",
                     out_pc_a, out_valid_a, occupancy_a, in_ready_a);
        end
        tick();
    endtask

    task automatic test_stream();
        bit ok;
        seen_pc.delete();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            in_pc = 32'h3000 + 32'(4 * i);
            rand_fields();
            #1;
            n_vec++;
            if (observe() !== expect_now()) begin
                n_bad++; $display("FAIL stream_cyc%0d: got %h want %h", i, observe(), expect_now());
            end
            if (i >= 1 && i <= 4) begin
                n_vec++;
                if (occupancy_a !== 2'd1 || out_valid_a !== 1'b1 || out_pc_a !== 32'h3000 + 32'(4 * (i - 1))) begin
                    n_bad++;
                    $display("FAIL stream_head%0d: got occ=%0d vld=%b pc=%h want occ=1 vld=1 pc=%h",
                             i, occupancy_a, out_valid_a, out_pc_a, 32'h3000 + 32'(4 * (i - 1)));
                end
            end
            tick();
        end
        ok = (seen_pc.size() == 4);
        for (int i = 0; i < 4 && ok; i++) if (seen_pc[i] !== 32'h3000 + 32'(4 * i)) ok = 0;
        n_vec++;
        if (!ok) begin
            n_bad++; $display("FAIL stream_order: got %0d beats want 4 in order 3000..300c", seen_pc.size());
        end
        idle();
    endtask

    task automatic test_stall();
        logic [31:0] pcs[3];
        int  idx;
        bit  acc, ok;
        pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
        seen_pc.delete();
        idx = 0;
        rand_fields();
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 4);
            in_valid  = (idx < 3);
            in_pc     = (idx < 3) ? pcs[idx] : 32'h0;
            #1;
            n_vec++;
            if (observe() !== expect_now()) begin
                n_bad++; $display("FAIL stall_cyc%0d: got %h want %h", c, observe(), expect_now());
            end
            if (c == 3) begin
                n_vec++;
                if (occupancy_a !== 2'd2 || in_ready_a !== 1'b0 || out_pc_a !== 32'h3000) begin
                    n_bad++;
                    $display("FAIL stall_full: got occ=%0d rdy=%b pc=%h want occ=2 rdy=0 pc=00003000",
                             occupancy_a, in_ready_a, out_pc_a);
                end
            end
            acc = in_valid && m_in_ready();
            tick();
            if (acc) begin idx++; rand_fields(); end
        end
        ok = (seen_pc.size() == 3);
        for (int i = 0; i < 3 && ok; i++) if (seen_pc[i] !== pcs[i]) ok = 0;
        n_vec++;
        if (!ok) begin
            n_bad++; $display("FAIL stall_order: got %0d beats want 3 in order 3000,3004,3008", seen_pc.size());
        end
        idle();
    endtask

    task automatic test_req();
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1; in_pc = 32'h3100 + 32'(4 * c); rand_fields();
            req = (c == 2);
            #1;
            n_vec++;
            if (observe() !== expect_now()) begin
                n_bad++; $display("FAIL req_cyc%0d: got %h want %h", c, observe(), expect_now());
            end
            tick();
        end
        req = 0; in_valid = 0;
        #1;
        n_vec++;
        if (out_valid_a !== 1'b0 || out_pc_a !== 32'h4180 || out_instr_a !== 32'h0 ||
            occupancy_a !== 2'd0 || in_ready_a !== 1'b1) begin
            n_bad++;
            $display("FAIL req_result: got vld=%b pc=%h instr=%h occ=%0d rdy=%b want vld=0 pc=00004180 instr=0 occ=0 rdy=1",
                     out_valid_a, out_pc_a, out_instr_a, occupancy_a, in_ready_a);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0;
        in_valid = 1; in_pc = 32'h3010; rand_fields();
        #1;
        tick();
        in_pc = 32'h3014; rand_fields(); flush = 1;
        #1;
        n_vec++;
        if (out_valid_a !== 1'b1 || out_pc_a !== 32'h3010) begin
            n_bad++; $display("FAIL flush_pre: got vld=%b pc=%h want vld=1 pc=00003010", out_valid_a, out_pc_a);
        end
        tick();
        flush = 0; in_valid = 0;
        #1;
        n_vec++;
        if (out_valid_a !== 1'b0 || out_pc_a !== 32'h3010 || out_instr_a !== 32'h0 || occupancy_a !== 2'd0) begin
            n_bad++;
            $display("FAIL flush_result: got vld=%b pc=%h instr=%h occ=%0d want vld=0 pc=00003010 instr=0 occ=0",
                     out_valid_a, out_pc_a, out_instr_a, occupancy_a);
        end
        n_vec++;
        if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL flush_model: got %h want %h", observe(), expect_now());
        end
        tick();
        #1;
        n_vec++;
        if (out_valid_a !== 1'b0) begin
            n_bad++; $display("FAIL flush_dropped: got vld=%b want 0", out_valid_a);
        end
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_pc     = $urandom;
            rand_fields();
            req   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            #1;
            n_vec++;
            if (observe() !== expect_now()) begin
                n_bad++; $display("FAIL random_sel%0d_cyc%0d: got %h want %h", sel, c, observe(), expect_now());
            end
            tick();
        end
        idle(); rst = 0;
    endtask

    task automatic test_skid0();
        sel = 1; m_skid = 0; dmask = 32'h0000_00FF;
        idle(); rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_vec++;
        if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL skid0_reset: got %h want %h", observe(), expect_now());
        end
        tick();
        in_valid = 1; in_pc = 32'h3200; rand_fields(); in_data = 32'h0000_00A5;
        #1;
        tick();
        in_pc = 32'h3204; rand_fields(); in_data = 32'h0000_005A;
        #1;
        n_vec++;
        if (in_ready_b !== 1'b0 || out_valid_b !== 1'b1) begin
            n_bad++; $display("FAIL skid0_stall: got rdy=%b vld=%b want rdy=0 vld=1", in_ready_b, out_valid_b);
        end
        out_ready = 1;
        #1;
        n_vec++;
        if (in_ready_b !== 1'b1 || out_data_b !== 8'hA5) begin
            n_bad++; $display("FAIL skid0_release: got rdy=%b data=%h want rdy=1 data=a5", in_ready_b, out_data_b);
        end
        n_vec++;
        if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL skid0_model: got %h want %h", observe(), expect_now());
        end
        tick();
        in_valid = 0;
        #1;
        n_vec++;
        if (out_valid_b !== 1'b1 || out_data_b !== 8'h5A || occupancy_b !== 2'd1) begin
            n_bad++;
            $display("FAIL skid0_next: got vld=%b data=%h occ=%0d want vld=1 data=5a occ=1",
                     out_valid_b, out_data_b, occupancy_b);
        end
        tick();
    endtask

    initial begin
        shown = '0;
        test_reset();
        test_stream();
        test_stall();
        test_req();
        test_flush();
        test_random(400);
        test_skid0();
        test_random(300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the P7 MIPS pipeline. It generalises the fixed MEM/WB latch.
- Carries PC, instruction, a DW-bit payload, exception code and branch-delay flag between stages.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so a stalled consumer never creates a combinational ready path back to the producer.
- Supports exception flush (redirect to the handler PC) and plain kill flush.

Parameters:
- DW, 32: payload width in bits (any value ≥ 1).
- SKID, 1: 1 selects the 2-entry skid buffer with registered in_ready. 0 selects a single entry with combinational in_ready.
- RESET_PC, 32'h0000_3000: out_pc value after reset.
- HANDLER_PC, 32'h0000_4180: out_pc value after an exception flush.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high.
- req, input, 1: exception flush. Discards all entries and loads HANDLER_PC.
- flush, input, 1: kill flush. Discards all entries; out_pc is kept.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_pc, input, 32: upstream PC.
- in_instr, input, 32: upstream instruction word.
- in_data, input, DW: upstream payload.
- in_excode, input, 5: upstream exception code (0 = none).
- in_bd, input, 1: upstream branch-delay-slot flag.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts the head entry.
- out_pc, output, 32: head PC.
- out_instr, output, 32: head instruction.
- out_data, output, DW: head payload.
- out_excode, output, 5: head exception code.
- out_bd, output, 1: head branch-delay flag.
- occupancy, output, 2: number of valid entries (0..2).

Behaviour:
- Reset: clk and reset — reset is synchronous and active-high, clock is clk.
- Storage: a main register (head, drives all out_* ports) and, when SKID=1, one skid register.
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - A beat transfers only on a rising edge where its event is true.
- in_ready:
  - SKID=1: registered; equals ~skid_valid.
  - SKID=0: combinational; ~out_valid | out_ready.
- Update priority per edge is reset > req > flush > normal.
- reset: all entries invalid; out_pc=RESET_PC; out_instr, out_data, out_excode, out_bd = 0; occupancy=0; in_ready=1 from the next cycle.
- req: same as reset except out_pc=HANDLER_PC. A beat offered in the same cycle is dropped, not captured.
- flush: all entries invalid; out_instr, out_data, out_excode, out_bd = 0; out_pc holds its current value. A same-cycle beat is dropped.
- Normal operation, SKID=1:
  - Main empty, accept: input → main.
  - Main valid, drain, skid empty, accept: input → main.
  - Main valid, drain, skid empty, no accept: main invalid; out_* fields hold their last values.
  - Main valid, no drain, accept: input → skid; in_ready=0 on the next cycle.
  - Skid valid, drain: skid → main, skid invalid; in_ready=1 on the next cycle. No accept is possible in this cycle because in_ready=0.
  - Neither event: hold.
- Normal operation, SKID=0: accept loads main; drain without accept invalidates main.
- Latency: one cycle from accept to out_valid when the stage is empty. Throughput is one beat per cycle while out_ready=1.
- Ordering: strict FIFO; the skid entry is never bypassed by a newer beat.
- Invariants:
  - out_valid=0 implies occupancy=0.
  - Skid valid implies main valid.
  - occupancy = main_valid + skid_valid.
- Out_* fields are meaningful only while out_valid=1. When invalid they hold their last value, except after reset/req/flush, which force the zeros and PC values listed above.
- Widths are exact. No arithmetic is performed; out_data is bit-identical to in_data for any DW.

Test Plan:
- Reset → out_pc=32'h3000, out_valid=0, occupancy=0, in_ready=1 on the cycle after reset deasserts.
- Stream 4 beats, PC 0x3000/0x3004/0x3008/0x300C, out_ready=1 → each appears one cycle after accept, back-to-back, occupancy stays 1.
- Hold out_ready=0 and offer 3 beats (PC 0x3000, 0x3004, 0x3008) → first two captured, occupancy=2, in_ready=0, third beat held upstream. Raise out_ready → order 0x3000, 0x3004, 0x3008 with no loss or duplication.
- With occupancy=2 and in_valid=1, pulse req → next cycle out_valid=0, out_pc=32'h4180, out_instr=0, occupancy=0, in_ready=1.
- With out_pc=0x3010 valid, pulse flush together with in_valid=1 → out_valid=0, out_pc stays 0x3010, in_instr of that cycle is dropped.
- SKID=0, DW=8: in_data=8'hA5, out_ready=0 → in_ready=0 immediately. Raise out_ready → in_ready=1 in the same cycle, and out_data=8'hA5 transfers.
